// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform stage.
// Holds the fixed data-path widths, the waveform select encoding,
// the offset-binary midscale value and the pipeline latency.
package dds_pkg;

    localparam int unsigned AW        = 8;   // phase address width
    localparam int unsigned DW        = 8;   // sample width, offset binary
    localparam int unsigned LUT_DEPTH = 64;  // quarter-wave sine entries
    localparam int unsigned WAVE_LAT  = 3;   // addr_vld -> sample_vld, cycles

    localparam logic [DW-1:0] MIDSCALE = DW'(128);

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SAW  = 2'd2,
        WAVE_SQR  = 2'd3
    } wave_e;

endpackage

// File: rtl/dds_wave_gen_if.sv
// Bus between the phase accumulator / DAC driver side and the waveform stage.
//   addr_in, addr_vld : phase address stream from the accumulator
//   wave_sel, amp     : requested waveform and amplitude (gain amp/256)
//   sample_out/_vld   : scaled offset-binary sample towards the DAC driver
//   wave_cur          : waveform currently being applied
// master drives the request side, slave is the waveform generator.
interface dds_wave_gen_if;
    import dds_pkg::*;

    logic [AW-1:0] addr_in;
    logic          addr_vld;
    logic [1:0]    wave_sel;
    logic [7:0]    amp;
    logic [DW-1:0] sample_out;
    logic          sample_vld;
    logic [1:0]    wave_cur;

    modport master (
        output addr_in, addr_vld, wave_sel, amp,
        input  sample_out, sample_vld, wave_cur
    );

    modport slave (
        input  addr_in, addr_vld, wave_sel, amp,
        output sample_out, sample_vld, wave_cur
    );

endinterface

// File: rtl/dds_sine_qlut.sv
// Quarter-wave sine ROM, combinational.
//   idx_i : quarter-wave index 0..63
//   mag_o : round(127*sin(pi/2*(idx+0.5)/64)), 7-bit magnitude
// The half-LSB offset keeps the table symmetric so mirroring the index
// for the second quarter needs no correction term.
module dds_sine_qlut
    import dds_pkg::*;
(
    input  logic [$clog2(LUT_DEPTH)-1:0] idx_i,
    output logic [6:0]                   mag_o
);

    always_comb begin
        mag_o = 7'd0;
        case (idx_i)
            6'd0:  mag_o = 7'd2;   6'd1:  mag_o = 7'd5;   6'd2:  mag_o = 7'd8;   6'd3:  mag_o = 7'd11;
            6'd4:  mag_o = 7'd14;  6'd5:  mag_o = 7'd17;  6'd6:  mag_o = 7'd20;  6'd7:  mag_o = 7'd23;
            6'd8:  mag_o = 7'd26;  6'd9:  mag_o = 7'd29;  6'd10: mag_o = 7'd32;  6'd11: mag_o = 7'd35;
            6'd12: mag_o = 7'd38;  6'd13: mag_o = 7'd41;  6'd14: mag_o = 7'd44;  6'd15: mag_o = 7'd47;
            6'd16: mag_o = 7'd50;  6'd17: mag_o = 7'd53;  6'd18: mag_o = 7'd56;  6'd19: mag_o = 7'd58;
            6'd20: mag_o = 7'd61;  6'd21: mag_o = 7'd64;  6'd22: mag_o = 7'd67;  6'd23: mag_o = 7'd69;
            6'd24: mag_o = 7'd72;  6'd25: mag_o = 7'd74;  6'd26: mag_o = 7'd77;  6'd27: mag_o = 7'd79;
            6'd28: mag_o = 7'd82;  6'd29: mag_o = 7'd84;  6'd30: mag_o = 7'd86;  6'd31: mag_o = 7'd89;
            6'd32: mag_o = 7'd91;  6'd33: mag_o = 7'd93;  6'd34: mag_o = 7'd95;  6'd35: mag_o = 7'd97;
            6'd36: mag_o = 7'd99;  6'd37: mag_o = 7'd101; 6'd38: mag_o = 7'd103; 6'd39: mag_o = 7'd105;
            6'd40: mag_o = 7'd106; 6'd41: mag_o = 7'd108; 6'd42: mag_o = 7'd110; 6'd43: mag_o = 7'd111;
            6'd44: mag_o = 7'd113; 6'd45: mag_o = 7'd114; 6'd46: mag_o = 7'd115; 6'd47: mag_o = 7'd117;
            6'd48: mag_o = 7'd118; 6'd49: mag_o = 7'd119; 6'd50: mag_o = 7'd120; 6'd51: mag_o = 7'd121;
            6'd52: mag_o = 7'd122; 6'd53: mag_o = 7'd123; 6'd54: mag_o = 7'd124; 6'd55: mag_o = 7'd124;
            6'd56: mag_o = 7'd125; 6'd57: mag_o = 7'd125; 6'd58: mag_o = 7'd126; 6'd59: mag_o = 7'd126;
            6'd60: mag_o = 7'd127; 6'd61: mag_o = 7'd127; 6'd62: mag_o = 7'd127; 6'd63: mag_o = 7'd127;
            default: mag_o = 7'd0;
        endcase
    end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform stage: turns the 8-bit phase address stream into a sine,
// triangle, sawtooth or square sample, scaled by amp/256, offset binary.
//   clk : system clock
//   rst : synchronous reset, active-high; flushes the pipeline
//   bus : dds_wave_gen_if slave (address stream in, samples out)
// Three register stages: address/waveform capture, raw sample, scaling.
// A waveform request is only adopted at a phase wrap (or the first valid
// address after reset) so a period is never built from two waveforms.
module dds_wave_gen
    import dds_pkg::*;
(
    input logic           clk,
    input logic           rst,
    dds_wave_gen_if.slave bus
);

    // Stage 1: address register and waveform switch-over
    logic          s1_vld_q;
    logic [AW-1:0] s1_addr_q;
    wave_e         wave_cur_q;
    logic          prev_msb_q;
    logic          seen_q;
    logic          wrap;

    // prev_msb_q only advances on valid cycles, so idle gaps cannot fake a wrap
    assign wrap = prev_msb_q & ~bus.addr_in[AW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            wave_cur_q <= WAVE_SINE;
            prev_msb_q <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            s1_vld_q <= bus.addr_vld;
            if (bus.addr_vld) begin
                s1_addr_q  <= bus.addr_in;
                prev_msb_q <= bus.addr_in[AW-1];
                seen_q     <= 1'b1;
                if (wrap || !seen_q) begin
                    wave_cur_q <= wave_e'(bus.wave_sel);
                end
            end
        end
    end

    assign bus.wave_cur = wave_cur_q;

    // Stage 2: raw waveform sample
    logic [5:0]    sine_idx;
    logic [6:0]    sine_mag;
    logic [DW-1:0] raw_d;
    logic          s2_vld_q;
    logic [DW-1:0] s2_raw_q;
    logic [7:0]    s2_amp_q;

    // Second and fourth quarters read the table mirrored
    assign sine_idx = s1_addr_q[6] ? ~s1_addr_q[5:0] : s1_addr_q[5:0];

    dds_sine_qlut u_sine_qlut (
        .idx_i (sine_idx),
        .mag_o (sine_mag)
    );

    always_comb begin
        raw_d = MIDSCALE;
        case (wave_cur_q)
            WAVE_SINE: raw_d = s1_addr_q[7] ? (8'd127 - {1'b0, sine_mag})
                                            : (MIDSCALE + {1'b0, sine_mag});
            WAVE_TRI:  raw_d = s1_addr_q[7] ? ~{s1_addr_q[6:0], 1'b0}
                                            : {s1_addr_q[6:0], 1'b0};
            WAVE_SAW:  raw_d = s1_addr_q;
            WAVE_SQR:  raw_d = s1_addr_q[7] ? 8'd0 : 8'd255;
            default:   raw_d = MIDSCALE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_raw_q <= MIDSCALE;
            s2_amp_q <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_raw_q <= raw_d;
                s2_amp_q <= bus.amp;
            end
        end
    end

    // Stage 3: scale around midscale
    logic signed [8:0]  centred;
    logic signed [17:0] prod;
    logic [DW-1:0]      sample_d;
    logic [DW-1:0]      sample_q;
    logic               sample_vld_q;
    logic               unused_prod;

    assign centred = $signed({1'b0, s2_raw_q}) - 9'sd128;
    assign prod    = 18'(centred) * $signed({10'd0, s2_amp_q});
    // prod >>> 8 lies in -128..126, so its low byte plus 128 (mod 256) is the
    // offset-binary result; dropping prod[7:0] is the floor shift
    assign sample_d    = prod[15:8] + MIDSCALE;
    assign unused_prod = ^{prod[17:16], prod[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_vld_q <= 1'b0;
            sample_q     <= MIDSCALE;
        end else begin
            sample_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                sample_q <= sample_d;
            end
        end
    end

    assign bus.sample_out = sample_q;
    assign bus.sample_vld = sample_vld_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed cases plus a randomized
// stream, all compared every cycle against a behavioural model.
module tb_dds_wave_gen;
    import dds_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dds_wave_gen_if bus ();

    dds_wave_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;

    int   sine_lut [64];
    exp_t exp_q [$];
    int   obs_q [$];
    int   cyc = 0;
    int   m_wave = 0;
    int   m_last = 128;
    bit   m_vld = 1'b0;
    bit   m_prev_msb = 1'b0;
    bit   m_seen = 1'b0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic int ref_raw(input int a, input int w);
        int q;
        int mag;
        case (w)
            0: begin
                q = a % 64;
                if ((a / 64) % 2 == 1) q = 63 - q;
                mag = sine_lut[q];
                return (a < 128) ? 128 + mag : 127 - mag;
            end
            1:       return (a < 128) ? 2 * a : 255 - 2 * (a - 128);
            2:       return a;
            default: return (a < 128) ? 255 : 0;
        endcase
    endfunction

    function automatic int ref_scale(input int raw, input int amp);
        int p;
        p = (raw - 128) * amp;
        return 128 + (p >>> 8);
    endfunction

    // Predict the visible state after the upcoming clock edge
    task automatic model_edge();
        int   a;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_last     = 128;
            m_vld      = 1'b0;
            m_wave     = 0;
            m_prev_msb = 1'b0;
            m_seen     = 1'b0;
            return;
        end
        if (bus.addr_vld) begin
            a = int'(bus.addr_in);
            if (!m_seen || (m_prev_msb && a < 128)) m_wave = int'(bus.wave_sel);
            m_prev_msb = (a >= 128);
            m_seen     = 1'b1;
            e.due = cyc + int'(WAVE_LAT) - 1;
            e.val = ref_scale(ref_raw(a, m_wave), int'(bus.amp));
            exp_q.push_back(e);
        end
        m_vld = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_vld  = 1'b1;
            m_last = exp_q[0].val;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("sample_vld", int'(bus.sample_vld), int'(m_vld));
        check("sample_out", int'(bus.sample_out), m_last);
        check("wave_cur", int'(bus.wave_cur), m_wave);
        if (bus.sample_vld) obs_q.push_back(int'(bus.sample_out));
        cyc++;
    endtask

    task automatic send(input int a);
        bus.addr_vld = 1'b1;
        bus.addr_in  = 8'(a);
        tick();
    endtask

    task automatic idle(input int n);
        bus.addr_vld = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int step;
        int phase;

        for (int i = 0; i < 64; i++) begin
            sine_lut[i] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 128.0) + 0.5);
        end

        rst          = 1'b1;
        bus.addr_in  = '0;
        bus.addr_vld = 1'b0;
        bus.wave_sel = 2'd0;
        bus.amp      = 8'd0;
        tick();
        tick();
        check("rst_vld", int'(bus.sample_vld), 0);
        check("rst_out", int'(bus.sample_out), 128);
        check("rst_wave", int'(bus.wave_cur), 0);
        rst = 1'b0;

        // Square, full amplitude
        bus.wave_sel = 2'd3;
        bus.amp      = 8'd255;
        obs_q.delete();
        send(0);
        send(128);
        idle(3);
        check("sqr_count", obs_q.size(), 2);
        check("sqr_hi", obs_q[0], 254);
        check("sqr_lo", obs_q[1], 0);
        check("sqr_wave", int'(bus.wave_cur), 3);

        // Triangle, half amplitude; addr 0 after 128 is a wrap
        bus.wave_sel = 2'd1;
        bus.amp      = 8'd128;
        obs_q.delete();
        send(0);
        send(64);
        send(128);
        send(255);
        idle(3);
        check("tri_0", obs_q[0], 64);
        check("tri_64", obs_q[1], 128);
        check("tri_128", obs_q[2], 191);
        check("tri_255", obs_q[3], 64);
        check("tri_wave", int'(bus.wave_cur), 1);

        // Sine spot values, then a full sweep
        bus.wave_sel = 2'd0;
        bus.amp      = 8'd255;
        obs_q.delete();
        send(0);
        send(64);
        send(192);
        idle(3);
        check("sin_0", obs_q[0], 129);
        check("sin_64", obs_q[1], 254);
        check("sin_192", obs_q[2], 0);
        for (int a = 0; a < 256; a++) send(a);
        idle(3);

        // Sawtooth at zero amplitude: constant midscale
        bus.wave_sel = 2'd2;
        bus.amp      = 8'd0;
        obs_q.delete();
        for (int a = 0; a < 256; a++) send(a);
        idle(3);
        check("saw0_count", obs_q.size(), 256);
        foreach (obs_q[i]) check("saw0_mid", obs_q[i], 128);
        check("saw_wave", int'(bus.wave_cur), 2);

        // Running sine, step 16; request sawtooth mid-period
        bus.wave_sel = 2'd0;
        bus.amp      = 8'd200;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) begin
                if (p == 1 && k == 6) bus.wave_sel = 2'd2;
                send(16 * k);
                if (p == 1 && k == 15) check("hold_wave", int'(bus.wave_cur), 0);
                if (p == 2 && k == 0) check("wrap_wave", int'(bus.wave_cur), 2);
            end
        end
        idle(3);

        // Gapped stream with a reset pulse in the middle
        bus.wave_sel = 2'd1;
        bus.amp      = 8'd255;
        for (int i = 0; i < 30; i++) begin
            rst          = (i == 14);
            bus.addr_vld = (i % 3 == 0);
            bus.addr_in  = 8'(i * 8);
            tick();
            if (i == 14) begin
                check("rst_mid_vld", int'(bus.sample_vld), 0);
                check("rst_mid_out", int'(bus.sample_out), 128);
            end
        end
        rst = 1'b0;
        idle(3);

        // Randomized segments
        for (int seg = 0; seg < 12; seg++) begin
            rst = 1'b0;
            idle(3);
            bus.amp = 8'($urandom_range(0, 255));
            step    = int'($urandom_range(1, 40));
            phase   = int'($urandom_range(0, 255));
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 19) == 0) bus.wave_sel = 2'($urandom_range(0, 3));
                rst          = ($urandom_range(0, 199) == 0);
                bus.addr_vld = ($urandom_range(0, 9) < 7);
                bus.addr_in  = 8'(phase);
                if (bus.addr_vld) phase = (phase + step) % 256;
                tick();
            end
        end
        rst = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
- Waveform stage directly downstream of the DDS phase accumulator.
- Consumes the 8-bit phase address stream and produces sine, triangle, sawtooth or square samples in offset-binary, amplitude-scaled, for the DAC driver.
- Waveform changes take effect only at a phase wrap, so the output never glitches mid-period.
- Three-stage pipeline with a valid flag carried alongside the data.

Parameters:
- AW, 8: phase address width. Fixed at 8; the block is only specified for 8.
- DW, 8: sample width, offset binary, midscale 128.
- LUT_DEPTH, 64: quarter-wave sine table entries.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- addr_in  in  AW  phase address from the accumulator.
- addr_vld  in  1  addr_in is valid this cycle.
- wave_sel  in  2  requested waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square.
- amp  in  8  amplitude scale; gain is amp/256.
- sample_out  out  DW  scaled sample.
- sample_vld  out  1  sample_out is valid.
- wave_cur  out  2  waveform currently applied.

Behaviour:
- The design has one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - sample_out = 128, sample_vld = 0, wave_cur = 0.
  - All pipeline valids are cleared.
  - The "first valid seen" flag is cleared, and prev_msb is cleared.
- Reset asserted mid-stream flushes all in-flight samples; no valid output appears until 3 cycles after the first post-reset addr_vld.
- Latency: sample_vld(t+3) = addr_vld(t), with no bubbles or stalls.
- Each stage register loads only when its incoming valid is 1. Otherwise it holds, so sample_out keeps the last valid sample.
- Stage 1 (register address):
  - Register addr_in.
  - Wrap event = valid address with addr_in[7]=0 while prev_msb=1. prev_msb is updated on valid cycles only.
  - wave_cur loads wave_sel on a wrap event, or on the first valid after reset. wave_sel is sampled in the same cycle, so a change coinciding with the wrap is applied.
  - wave_sel changes at any other time are ignored until the next wrap.
- Stage 2 (raw sample), with a = address and wave = wave_cur as captured with this address. Register the raw sample and amp.
  - Sine:
    - q = a[6] ? ~a[5:0] : a[5:0].
    - mag = LUT[q], where LUT[i] = round(127*sin(pi/2*(i+0.5)/64)), 7-bit.
    - raw = a[7] ? 127-mag : 128+mag.
  - Triangle: a[7] ? ~{a[6:0],1'b0} : {a[6:0],1'b0}. This gives 0..254 rising and 255..1 falling.
  - Sawtooth: raw = a.
  - Square: raw = a[7] ? 0 : 255.
- Stage 3 (scale):
  - s = raw - 128, signed 9-bit.
  - p = s*amp, signed 17-bit.
  - sample_out = 128 + (p >>> 8), using an arithmetic floor shift.
  - Result range is 0..254, so no saturation is needed.
- Boundary cases:
  - amp = 0 gives a constant 128.
  - addr_vld low for many cycles does not create a false wrap, because prev_msb holds.

Decomposition:
- Shared package dds_pkg holds:
  - Waveform enum constants: WAVE_SINE = 0, WAVE_TRI = 1, WAVE_SAW = 2, WAVE_SQR = 3.
  - MIDSCALE = 128.
  - The pipeline latency constant WAVE_LAT = 3.
- One sub-module, dds_sine_qlut: a 64x7 combinational quarter-wave ROM (case table), instantiated in stage 2.

Test Plan:
- Reset, then wave_sel=3, amp=255, addr 0 valid -> after 3 cycles sample_vld=1, sample_out=254, wave_cur=3. Addr 128 valid -> sample_out=0.
- Sawtooth, amp=0, sweep addr 0..255 -> every valid output = 128.
- Triangle, amp=128, addr 0, 64, 128, 255 -> raw 0, 128, 255, 1 -> sample_out 64, 128, 191, 64.
- Sine, amp=255, addr 0 / 64 / 192 -> raw 130 / 255 / 0 -> out 129 / 254 / 0. A full sweep is checked against a model using the same LUT.
- Running sine (FWORD-like step 16): change wave_sel to 2 at addr 96 -> wave_cur stays 0 until the first valid addr with MSB 0 after MSB 1 (addr 0). The first sawtooth sample is that addr, and no mixed samples occur.
- Gapped addr_vld (every 3rd cycle) with rst pulsed mid-stream -> sample_vld=0 and sample_out=128 the cycle after reset. Output resumes exactly 3 cycles after the next valid, and the held output is unchanged during gaps.
